// File: rtl/wb_stage_pipe_if.sv
// Write-back stage bus: MEM-side op/response inputs and register-file write outputs.
interface wb_stage_pipe_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_alu_out;
  logic [DATA_W-1:0]     in_pc;
  logic [15:0]           in_imm16;
  logic [REG_ADDR_W-1:0] in_rd;
  logic                  in_reg_write;
  logic                  in_mem_to_reg;
  logic                  in_lhi;
  logic                  in_link;
  logic [1:0]            in_size;
  logic                  in_load_ext;
  logic [1:0]            in_addr_lo;
  logic                  mem_rsp_valid;
  logic [DATA_W-1:0]     mem_rsp_data;
  logic                  flush;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0]     rf_wdata;
  logic                  misalign_err;
  logic [31:0]           retire_count;

  // Upstream / environment side
  modport master (
    output in_valid, in_alu_out, in_pc, in_imm16, in_rd, in_reg_write,
           in_mem_to_reg, in_lhi, in_link, in_size, in_load_ext, in_addr_lo,
           mem_rsp_valid, mem_rsp_data, flush,
    input  in_ready, rf_we, rf_waddr, rf_wdata, misalign_err, retire_count
  );

  // Write-back stage side
  modport slave (
    input  in_valid, in_alu_out, in_pc, in_imm16, in_rd, in_reg_write,
           in_mem_to_reg, in_lhi, in_link, in_size, in_load_ext, in_addr_lo,
           mem_rsp_valid, mem_rsp_data, flush,
    output in_ready, rf_we, rf_waddr, rf_wdata, misalign_err, retire_count
  );
endinterface

// File: rtl/wb_stage_pipe.sv
// Write-back stage: result select (lhi/link/load/ALU), sub-word load alignment,
// late-load wait FSM with flush, registered rf write port and retire counter.
module wb_stage_pipe #(
  parameter int DATA_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int LINK_OFFSET = 8,
  parameter int LINK_REG    = 31
) (
  input  logic           clk,
  input  logic           rst_n,
  wb_stage_pipe_if.slave wb
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  typedef struct packed {
    logic [DATA_W-1:0]     alu;
    logic [DATA_W-1:0]     pc;
    logic [15:0]           imm16;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic                  lhi;
    logic                  link;
    logic [1:0]            size;
    logic                  load_ext;
    logic [1:0]            addr_lo;
  } op_t;

  state_t                state_q;
  op_t                   cap_q;
  logic                  rf_we_q;
  logic [REG_ADDR_W-1:0] rf_waddr_q;
  logic [DATA_W-1:0]     rf_wdata_q;
  logic                  misalign_q;
  logic [31:0]           retire_q;

  op_t                   live_op;
  op_t                   cur_op;
  logic                  live_is_load;
  logic                  cur_from_mem;
  logic [7:0]            ld_b;
  logic [15:0]           ld_h;
  logic [31:0]           ld_w;
  logic [DATA_W-1:0]     ld_ext;
  logic [DATA_W-1:0]     res_d;
  logic [REG_ADDR_W-1:0] dest_d;
  logic                  mis_d;
  logic                  we_d;
  logic                  accept_d;
  logic                  complete_d;

  // Pack the presented op so IDLE and WAIT share one datapath.
  always_comb begin
    live_op            = '0;
    live_op.alu        = wb.in_alu_out;
    live_op.pc         = wb.in_pc;
    live_op.imm16      = wb.in_imm16;
    live_op.rd         = wb.in_rd;
    live_op.reg_write  = wb.in_reg_write;
    live_op.mem_to_reg = wb.in_mem_to_reg;
    live_op.lhi        = wb.in_lhi;
    live_op.link       = wb.in_link;
    live_op.size       = wb.in_size;
    live_op.load_ext   = wb.in_load_ext;
    live_op.addr_lo    = wb.in_addr_lo;
  end

  // Only an op whose result actually comes from memory has to wait for data;
  // lhi/link win the result select and never need the response.
  assign cur_op       = (state_q == S_WAIT) ? cap_q : live_op;
  assign live_is_load = live_op.mem_to_reg & ~live_op.lhi & ~live_op.link;
  assign cur_from_mem = cur_op.mem_to_reg & ~cur_op.lhi & ~cur_op.link;

  // Load alignment by byte offset, then sign/zero extension to DATA_W.
  always_comb begin
    ld_b   = wb.mem_rsp_data[{cur_op.addr_lo, 3'b000} +: 8];
    ld_h   = wb.mem_rsp_data[{cur_op.addr_lo[1], 4'b0000} +: 16];
    ld_w   = wb.mem_rsp_data[31:0];
    ld_ext = '0;
    case (cur_op.size)
      2'b00:   ld_ext = cur_op.load_ext ? DATA_W'($signed(ld_b)) : DATA_W'(ld_b);
      2'b01:   ld_ext = cur_op.load_ext ? DATA_W'($signed(ld_h)) : DATA_W'(ld_h);
      default: ld_ext = cur_op.load_ext ? DATA_W'($signed(ld_w)) : DATA_W'(ld_w);
    endcase
  end

  // Result select, destination and write qualification for the completing op.
  always_comb begin
    if (cur_op.lhi)       res_d = {cur_op.imm16, {(DATA_W-16){1'b0}}};
    else if (cur_op.link) res_d = cur_op.pc + DATA_W'(LINK_OFFSET);
    else if (cur_from_mem) res_d = ld_ext;
    else                  res_d = cur_op.alu;
    dest_d = cur_op.link ? REG_ADDR_W'(LINK_REG) : cur_op.rd;
    mis_d  = cur_from_mem & (cur_op.size == 2'b01) & cur_op.addr_lo[0];
    we_d   = cur_op.reg_write & (dest_d != '0) & ~mis_d;
  end

  // Flush kills both a presented op and a pending load, even against a same-cycle response.
  assign accept_d   = (state_q == S_IDLE) & wb.in_valid & ~wb.flush;
  assign complete_d = (accept_d & (~live_is_load | wb.mem_rsp_valid)) |
                      ((state_q == S_WAIT) & ~wb.flush & wb.mem_rsp_valid);

  // FSM plus registered write port; write/misalign are single-cycle pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cap_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      misalign_q <= 1'b0;
      retire_q   <= '0;
    end else begin
      rf_we_q    <= 1'b0;
      misalign_q <= 1'b0;
      case (state_q)
        S_IDLE: if (accept_d && live_is_load && !wb.mem_rsp_valid) begin
          cap_q   <= live_op;
          state_q <= S_WAIT;
        end
        S_WAIT: if (wb.flush || wb.mem_rsp_valid) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      if (complete_d) begin
        rf_we_q    <= we_d;
        rf_waddr_q <= dest_d;
        rf_wdata_q <= res_d;
        misalign_q <= mis_d;
        retire_q   <= retire_q + 32'd1;
      end
    end
  end

  assign wb.in_ready     = rst_n & (state_q == S_IDLE);
  assign wb.rf_we        = rf_we_q;
  assign wb.rf_waddr     = rf_waddr_q;
  assign wb.rf_wdata     = rf_wdata_q;
  assign wb.misalign_err = misalign_q;
  assign wb.retire_count = retire_q;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed bench for wb_stage_pipe: vector table of single-cycle completions
// plus hand sequences for late loads, flush, counter wrap and mid-WAIT reset.
module tb_wb_stage_pipe;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  wb_stage_pipe_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

  wb_stage_pipe #(
    .DATA_W(32), .REG_ADDR_W(5), .LINK_OFFSET(8), .LINK_REG(31)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (bus)
  );

  typedef struct {
    logic [31:0] alu;
    logic [31:0] pc;
    logic [15:0] imm;
    logic [4:0]  rd;
    logic        rw;
    logic        m2r;
    logic        lhi;
    logic        link;
    logic [1:0]  size;
    logic        ext;
    logic [1:0]  lo;
    logic        rspv;
    logic [31:0] rsp;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_mis;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic clear_in();
    bus.in_valid      = 1'b0;
    bus.in_alu_out    = '0;
    bus.in_pc         = '0;
    bus.in_imm16      = '0;
    bus.in_rd         = '0;
    bus.in_reg_write  = 1'b0;
    bus.in_mem_to_reg = 1'b0;
    bus.in_lhi        = 1'b0;
    bus.in_link       = 1'b0;
    bus.in_size       = 2'b10;
    bus.in_load_ext   = 1'b0;
    bus.in_addr_lo    = 2'b00;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    bus.flush         = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    bus.in_valid      = 1'b1;
    bus.in_alu_out    = v.alu;
    bus.in_pc         = v.pc;
    bus.in_imm16      = v.imm;
    bus.in_rd         = v.rd;
    bus.in_reg_write  = v.rw;
    bus.in_mem_to_reg = v.m2r;
    bus.in_lhi        = v.lhi;
    bus.in_link       = v.link;
    bus.in_size       = v.size;
    bus.in_load_ext   = v.ext;
    bus.in_addr_lo    = v.lo;
    bus.mem_rsp_valid = v.rspv;
    bus.mem_rsp_data  = v.rsp;
    bus.flush         = 1'b0;
  endtask

  task automatic chk_out(input string nm, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic mis, input logic [31:0] cnt);
    chk({nm, " we"},    32'(bus.rf_we),        32'(we));
    chk({nm, " waddr"}, 32'(bus.rf_waddr),     32'(wa));
    chk({nm, " wdata"}, bus.rf_wdata,          wd);
    chk({nm, " mis"},   32'(bus.misalign_err), 32'(mis));
    chk({nm, " count"}, bus.retire_count,      cnt);
  endtask

  vec_t op;
  logic [31:0] exp_cnt;

  initial begin
    //          alu           pc            imm      rd  rw m2r lhi lnk size  ext lo     rspv rsp           we wa  wdata         mis
    vecs[0]  = '{32'h12345678, 32'h0,        16'h0,    3, 1, 0, 0, 0, 2'b10, 0, 2'd0, 0, 32'h0,        1, 3,  32'h12345678, 0};
    vecs[1]  = '{32'h0,        32'h0,        16'h0,    4, 1, 1, 0, 0, 2'b00, 1, 2'd2, 1, 32'h0080FF00, 1, 4,  32'hFFFFFF80, 0};
    vecs[2]  = '{32'h0,        32'h0,        16'h0,    4, 1, 1, 0, 0, 2'b00, 0, 2'd2, 1, 32'h0080FF00, 1, 4,  32'h00000080, 0};
    vecs[3]  = '{32'h0,        32'h0,        16'h0,    5, 1, 1, 0, 0, 2'b01, 1, 2'd1, 1, 32'h1234F00D, 0, 5,  32'hFFFFF00D, 1};
    vecs[4]  = '{32'h0,        32'h0,        16'h0,    5, 1, 1, 0, 0, 2'b01, 0, 2'd2, 1, 32'h80010000, 1, 5,  32'h00008001, 0};
    vecs[5]  = '{32'h0,        32'h0,        16'h0,    6, 1, 1, 0, 0, 2'b01, 1, 2'd2, 1, 32'h80010000, 1, 6,  32'hFFFF8001, 0};
    vecs[6]  = '{32'h0,        32'hFFFFFFFC, 16'h0,    7, 1, 0, 0, 1, 2'b10, 0, 2'd0, 0, 32'h0,        1, 31, 32'h00000004, 0};
    vecs[7]  = '{32'h0,        32'h00000100, 16'hABCD, 7, 1, 0, 1, 1, 2'b10, 0, 2'd0, 0, 32'h0,        1, 31, 32'hABCD0000, 0};
    vecs[8]  = '{32'hCAFEBABE, 32'h0,        16'h0,    0, 1, 0, 0, 0, 2'b10, 0, 2'd0, 0, 32'h0,        0, 0,  32'hCAFEBABE, 0};
    vecs[9]  = '{32'h11112222, 32'h0,        16'h0,    9, 0, 0, 0, 0, 2'b10, 0, 2'd0, 0, 32'h0,        0, 9,  32'h11112222, 0};
    vecs[10] = '{32'h0,        32'h0,        16'h0,   10, 1, 1, 0, 0, 2'b00, 1, 2'd3, 1, 32'hAB000000, 1, 10, 32'hFFFFFFAB, 0};
    vecs[11] = '{32'h0,        32'h0,        16'h0,   11, 1, 1, 0, 0, 2'b10, 1, 2'd3, 1, 32'hDEADBEEF, 1, 11, 32'hDEADBEEF, 0};
    vecs[12] = '{32'h0,        32'h0,        16'h0,   12, 1, 1, 0, 0, 2'b11, 0, 2'd1, 1, 32'h89ABCDEF, 1, 12, 32'h89ABCDEF, 0};
    vecs[13] = '{32'h0,        32'h0,        16'h0,   13, 1, 1, 0, 0, 2'b00, 1, 2'd0, 1, 32'h0000017F, 1, 13, 32'h0000007F, 0};
    vecs[14] = '{32'h5A5A5A5A, 32'h0,        16'h0,   14, 1, 0, 0, 0, 2'b10, 0, 2'd0, 1, 32'hFFFFFFFF, 1, 14, 32'h5A5A5A5A, 0};
    vecs[15] = '{32'h0,        32'h0,        16'h8000,15, 1, 1, 1, 0, 2'b00, 0, 2'd0, 0, 32'h0,        1, 15, 32'h80000000, 0};
    vecs[16] = '{32'h00000001, 32'h0,        16'h0,    1, 1, 0, 0, 0, 2'b10, 0, 2'd0, 0, 32'h0,        1, 1,  32'h00000001, 0};

    // Reset state
    rst_n = 1'b0;
    clear_in();
    repeat (2) @(negedge clk);
    chk("reset ready", 32'(bus.in_ready), 32'd0);
    chk_out("reset", 1'b0, 5'd0, 32'h0, 1'b0, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post-reset ready", 32'(bus.in_ready), 32'd1);

    // Back-to-back table: each op's result is checked while the next is presented
    exp_cnt = 0;
    for (int i = 0; i <= 17; i++) begin
      @(negedge clk);
      if (i > 0) begin
        exp_cnt = exp_cnt + 1;
        chk($sformatf("vec%0d ready", i-1), 32'(bus.in_ready), 32'd1);
        chk_out($sformatf("vec%0d", i-1), vecs[i-1].e_we, vecs[i-1].e_waddr,
                vecs[i-1].e_wdata, vecs[i-1].e_mis, exp_cnt);
      end
      if (i < 17) apply(vecs[i]);
      else        clear_in();
    end
    // Idle cycle: pulses drop, data holds
    @(negedge clk);
    chk_out("hold", 1'b0, 5'd1, 32'h00000001, 1'b0, exp_cnt);

    // Late load: lb sign, offset 1, response after 3 WAIT cycles
    op = '{32'h0, 32'h0, 16'h0, 6, 1, 1, 0, 0, 2'b00, 1, 2'd1, 0, 32'h0, 0, 0, 32'h0, 0};
    apply(op);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("late ready c%0d", c), 32'(bus.in_ready), 32'd0);
      chk($sformatf("late we c%0d", c), 32'(bus.rf_we), 32'd0);
      // A different op is presented during WAIT; it must be ignored
      op = '{32'hFFFFFFFF, 32'h0, 16'h0, 10, 1, 0, 0, 0, 2'b10, 1, 2'd3, 0, 32'h0, 0, 0, 32'h0, 0};
      apply(op);
      if (c == 2) begin
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'h00009300;
      end
    end
    @(negedge clk);
    exp_cnt = exp_cnt + 1;
    chk("late done ready", 32'(bus.in_ready), 32'd1);
    chk_out("late done", 1'b1, 5'd6, 32'hFFFFFF93, 1'b0, exp_cnt);
    clear_in();
    @(negedge clk);
    chk_out("late after", 1'b0, 5'd6, 32'hFFFFFF93, 1'b0, exp_cnt);

    // Flush in WAIT, racing a same-cycle response
    op = '{32'h0, 32'h0, 16'h0, 8, 1, 1, 0, 0, 2'b10, 0, 2'd0, 0, 32'h0, 0, 0, 32'h0, 0};
    apply(op);
    @(negedge clk);
    chk("flushw ready", 32'(bus.in_ready), 32'd0);
    clear_in();
    bus.flush         = 1'b1;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h77777777;
    @(negedge clk);
    chk("flushw ready after", 32'(bus.in_ready), 32'd1);
    chk_out("flushw", 1'b0, 5'd6, 32'hFFFFFF93, 1'b0, exp_cnt);
    clear_in();

    // Flush in IDLE drops presented op
    op = '{32'h13572468, 32'h0, 16'h0, 9, 1, 0, 0, 0, 2'b10, 0, 2'd0, 0, 32'h0, 0, 0, 32'h0, 0};
    apply(op);
    bus.flush = 1'b1;
    @(negedge clk);
    chk_out("flushi", 1'b0, 5'd6, 32'hFFFFFF93, 1'b0, exp_cnt);
    clear_in();

    // Stray response in IDLE is ignored
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h12121212;
    @(negedge clk);
    chk_out("stray rsp", 1'b0, 5'd6, 32'hFFFFFF93, 1'b0, exp_cnt);
    clear_in();

    // Retire counter wrap from preset all-ones
    @(negedge clk);
    dut.retire_q <= 32'hFFFFFFFF;
    op = '{32'h00000077, 32'h0, 16'h0, 2, 1, 0, 0, 0, 2'b10, 0, 2'd0, 0, 32'h0, 0, 0, 32'h0, 0};
    apply(op);
    #1;
    chk("preset count", bus.retire_count, 32'hFFFFFFFF);
    @(negedge clk);
    chk_out("wrap", 1'b1, 5'd2, 32'h00000077, 1'b0, 32'd0);
    clear_in();

    // Reset while a load is pending
    op = '{32'h0, 32'h0, 16'h0, 8, 1, 1, 0, 0, 2'b10, 0, 2'd0, 0, 32'h0, 0, 0, 32'h0, 0};
    apply(op);
    @(negedge clk);
    chk("rstw ready", 32'(bus.in_ready), 32'd0);
    clear_in();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstw ready in reset", 32'(bus.in_ready), 32'd0);
    chk_out("rstw", 1'b0, 5'd0, 32'h0, 1'b0, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rstw ready out", 32'(bus.in_ready), 32'd1);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'hFEEDFACE;
    @(negedge clk);
    chk_out("rstw rsp", 1'b0, 5'd0, 32'h0, 1'b0, 32'd0);
    clear_in();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end before 200000");
    $fatal(1);
  end

endmodule
